// File: rtl/circle_path_sequencer_pkg.sv
// Shared types and helpers for the circle-path sequencer and its renderer.
package circle_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned NUM_DIGITS_DEF = 6;
  localparam int unsigned NUM_POS        = 2 * NUM_DIGITS_DEF;
  localparam int unsigned POS_W          = 4;

  // Column select understood by the circle renderer.
  localparam logic UPPER = 1'b0;
  localparam logic LOWER = 1'b1;

  typedef struct packed {
    logic [2:0] row;
    logic       col;
  } index_t;

  // Upper circles run left to right, lower circles come back right to left.
  function automatic index_t pos_to_index(input logic [POS_W-1:0] pos,
                                          input int unsigned num_digits);
    index_t idx;
    if (32'(pos) < num_digits) begin
      idx.row = pos[2:0];
      idx.col = UPPER;
    end else begin
      idx.row = 3'(2 * num_digits - 1 - 32'(pos));
      idx.col = LOWER;
    end
    return idx;
  endfunction

endpackage

// File: rtl/circle_path_sequencer_if.sv
// Control and display-index bundle between board inputs and the sequencer.
interface circle_path_sequencer_if;
  logic       run_i;
  logic       dir_i;
  logic [1:0] speed_i;
  logic       step_i;
  logic [2:0] row_index_o;
  logic       column_index_o;
  logic       step_o;
  logic       lap_o;

  modport master (
    output run_i, dir_i, speed_i, step_i,
    input  row_index_o, column_index_o, step_o, lap_o
  );

  modport slave (
    input  run_i, dir_i, speed_i, step_i,
    output row_index_o, column_index_o, step_o, lap_o
  );
endinterface

// File: rtl/circle_path_sequencer_prescaler.sv
// Step-rate prescaler: period TICK_DIV >> shift cycles, terminal on cnt >= limit-1.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] shift,
  output logic       tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_limit;
  logic             w_terminal;

  assign w_limit = 32'(TICK_DIV) >> shift;
  // Greater-or-equal lets a mid-period speed-up fire immediately instead of
  // counting all the way round.
  assign w_terminal = (32'(r_cnt) >= (w_limit - 32'd1));
  assign tick       = en & w_terminal;

  // Count while enabled; clear on terminal count, on clear, or while disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr || !en || w_terminal) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/circle_path_sequencer.sv
// Walks a single lit circle around the display: upper row 0..N-1, lower row N-1..0.
module circle_path_sequencer
  import circle_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  circle_path_sequencer_if.slave   bus
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(2 * NUM_DIGITS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_pos_next;
  logic             w_wrap;
  logic             w_advance;
  logic             w_tick;
  logic             w_en;
  logic             w_clr;
  index_t           w_idx;

  logic [2:0]       r_row;
  logic             r_col;
  logic             r_step;
  logic             r_lap;

  // Prescaler runs only in RUN and is cleared whenever RUN is being left.
  assign w_en  = (r_state == RUN);
  assign w_clr = (r_state == STOP) || !bus.run_i;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (w_en),
    .clr   (w_clr),
    .shift (bus.speed_i),
    .tick  (w_tick)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= STOP;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and advance decision; a step coinciding with run rising is dropped.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      STOP: begin
        if (bus.run_i) begin
          w_state_next = RUN;
        end else if (bus.step_i) begin
          w_advance = 1'b1;
        end
      end
      RUN: begin
        w_advance = w_tick;
        if (!bus.run_i) begin
          w_state_next = STOP;
        end
      end
      default: w_state_next = STOP;
    endcase
  end

  // Next position in the selected direction, flagging the loop wrap.
  always_comb begin
    w_pos_next = r_pos;
    w_wrap     = 1'b0;
    if (!bus.dir_i) begin
      if (r_pos >= LAST_POS) begin
        w_pos_next = '0;
        w_wrap     = 1'b1;
      end else begin
        w_pos_next = r_pos + 1'b1;
      end
    end else begin
      if (r_pos == '0) begin
        w_pos_next = LAST_POS;
        w_wrap     = 1'b1;
      end else begin
        w_pos_next = r_pos - 1'b1;
      end
    end
    w_idx = pos_to_index(w_pos_next, NUM_DIGITS);
  end

  // Position and outputs are loaded from the next-position logic on the same
  // edge, so the indices never lag pos.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pos  <= '0;
      r_row  <= '0;
      r_col  <= UPPER;
      r_step <= 1'b0;
      r_lap  <= 1'b0;
    end else begin
      r_step <= w_advance;
      r_lap  <= w_advance & w_wrap;
      if (w_advance) begin
        r_pos <= w_pos_next;
        r_row <= w_idx.row;
        r_col <= w_idx.col;
      end
    end
  end

  assign bus.row_index_o    = r_row;
  assign bus.column_index_o = r_col;
  assign bus.step_o         = r_step;
  assign bus.lap_o          = r_lap;

endmodule
